// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/mem/writeback over one shared memory and ALU.
// Build macro ILLEGAL_TRAP_EN: unknown opcode/func traps to HALT and raises a sticky illegal output.
module multicycle_controller #(
  parameter int ALU_OP_W       = 5,
  parameter int MULDIV_CYCLES  = 32,
  parameter int BRANCH_OP_BASE = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          func,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                we_memory,
  output logic                memory_to_register,
  output logic [1:0]          destination_register,
  output logic                register_write,
  output logic                ALU_src_a,
  output logic [1:0]          ALU_src_b,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                hilo_write,
  output logic                busy,
  output logic                halt
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                illegal
`endif
);

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] OP_NOR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] OP_ADDU = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] OP_SUBU = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(10);
  localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(11);
  localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(12);
  localparam logic [ALU_OP_W-1:0] OP_LUI  = ALU_OP_W'(18);
  localparam logic [ALU_OP_W-1:0] OP_MFHI = ALU_OP_W'(19);
  localparam logic [ALU_OP_W-1:0] OP_MFLO = ALU_OP_W'(20);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MULDIV, S_MEM, S_WRITEBACK, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_RTYPE, C_ITYPE, C_LW, C_SW, C_BRANCH, C_J, C_JAL, C_JR, C_MULDIV, C_SYSCALL, C_ILLEGAL
  } cls_e;

  typedef struct packed {
    logic                pc_write;
    logic                pc_write_cond;
    logic [1:0]          pc_source;
    logic                i_or_d;
    logic                mem_read;
    logic                we_memory;
    logic                memory_to_register;
    logic [1:0]          destination_register;
    logic                register_write;
    logic                ALU_src_a;
    logic [1:0]          ALU_src_b;
    logic [ALU_OP_W-1:0] ALU_OP;
    logic                hilo_write;
    logic                busy;
    logic                halt;
  } ctl_t;

  function automatic cls_e classify(input logic [5:0] op, input logic [5:0] fn);
    cls_e c;
    c = C_ILLEGAL;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12: c = C_RTYPE;
          6'h08:                      c = C_JR;
          6'h0c:                      c = C_SYSCALL;
          6'h18, 6'h19, 6'h1a, 6'h1b: c = C_MULDIV;
          default:                    c = C_ILLEGAL;
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: c = C_ITYPE;
      6'h23:                             c = C_LW;
      6'h2b:                             c = C_SW;
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: c = C_BRANCH;
      6'h02:                             c = C_J;
      6'h03:                             c = C_JAL;
      default:                           c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic logic [ALU_OP_W-1:0] alu_sel(input logic [5:0] op, input logic [5:0] fn);
    logic [ALU_OP_W-1:0] a;
    a = OP_ADD;
    if (op == 6'h00) begin
      case (fn)
        6'h21:   a = OP_ADDU;
        6'h22:   a = OP_SUB;
        6'h23:   a = OP_SUBU;
        6'h24:   a = OP_AND;
        6'h25:   a = OP_OR;
        6'h26:   a = OP_XOR;
        6'h27:   a = OP_NOR;
        6'h2a:   a = OP_SLT;
        6'h2b:   a = OP_SLTU;
        6'h00:   a = OP_SLL;
        6'h02:   a = OP_SRL;
        6'h03:   a = OP_SRA;
        6'h10:   a = OP_MFHI;
        6'h12:   a = OP_MFLO;
        default: a = OP_ADD;
      endcase
    end else begin
      case (op)
        6'h09:   a = OP_ADDU;
        6'h0a:   a = OP_SLT;
        6'h0b:   a = OP_SLTU;
        6'h0c:   a = OP_AND;
        6'h0d:   a = OP_OR;
        6'h0e:   a = OP_XOR;
        6'h0f:   a = OP_LUI;
        6'h04:   a = ALU_OP_W'(BRANCH_OP_BASE);
        6'h05:   a = ALU_OP_W'(BRANCH_OP_BASE + 1);
        6'h06:   a = ALU_OP_W'(BRANCH_OP_BASE + 2);
        6'h07:   a = ALU_OP_W'(BRANCH_OP_BASE + 3);
        6'h01:   a = ALU_OP_W'(BRANCH_OP_BASE + 4);
        default: a = OP_ADD;
      endcase
    end
    return a;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, fn_q;
  ctl_t             ctl_q, ctl_d;
  logic             fetch_q;
  logic [5:0]       sel_op, sel_fn;
  cls_e             cls;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal_q, illegal_d;
`endif

  // While leaving DECODE the instruction is still on the inputs; afterwards only the latched copy counts.
  always_comb begin
    sel_op  = (state_q == S_DECODE) ? opcode : op_q;
    sel_fn  = (state_q == S_DECODE) ? func : fn_q;
    cls     = classify(sel_op, sel_fn);
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        case (cls)
          C_RTYPE, C_ITYPE: state_d = S_WRITEBACK;
          C_LW, C_SW:       state_d = S_MEM;
          C_MULDIV: begin
            state_d = S_MULDIV;
            cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
          end
          C_SYSCALL:        state_d = S_HALT;
          C_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d   = S_FETCH;
`endif
          end
          default:          state_d = S_FETCH;
        endcase
      end
      S_MULDIV: begin
        if (cnt_q == '0) state_d = S_FETCH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_MEM:       if (mem_ready) state_d = (cls == C_LW) ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded for the state about to be entered.
    ctl_d      = '0;
    ctl_d.busy = (state_d != S_IDLE) && (state_d != S_HALT);
    case (state_d)
      S_FETCH: begin
        ctl_d.mem_read  = 1'b1;
        ctl_d.ALU_src_b = 2'd1;
        ctl_d.ALU_OP    = OP_ADD;
      end
      S_DECODE: begin
        ctl_d.ALU_src_b = 2'd3;
        ctl_d.ALU_OP    = OP_ADD;
      end
      S_EXECUTE: begin
        case (cls)
          C_RTYPE, C_BRANCH: begin
            ctl_d.ALU_src_a     = 1'b1;
            ctl_d.ALU_OP        = alu_sel(sel_op, sel_fn);
            ctl_d.pc_write_cond = (cls == C_BRANCH);
            ctl_d.pc_source     = (cls == C_BRANCH) ? 2'd1 : 2'd0;
          end
          C_ITYPE, C_LW, C_SW: begin
            ctl_d.ALU_src_a = 1'b1;
            ctl_d.ALU_src_b = 2'd2;
            ctl_d.ALU_OP    = alu_sel(sel_op, sel_fn);
          end
          C_J: begin
            ctl_d.pc_write  = 1'b1;
            ctl_d.pc_source = 2'd2;
          end
          C_JAL: begin
            ctl_d.pc_write             = 1'b1;
            ctl_d.pc_source            = 2'd2;
            ctl_d.register_write       = 1'b1;
            ctl_d.destination_register = 2'd2;
          end
          C_JR: begin
            ctl_d.pc_write  = 1'b1;
            ctl_d.pc_source = 2'd3;
          end
          default: ;
        endcase
      end
      S_MULDIV: ctl_d.hilo_write = (cnt_d == '0);
      S_MEM: begin
        ctl_d.i_or_d    = 1'b1;
        ctl_d.mem_read  = (cls == C_LW);
        ctl_d.we_memory = (cls != C_LW);
      end
      S_WRITEBACK: begin
        ctl_d.register_write       = 1'b1;
        ctl_d.destination_register = (cls == C_RTYPE) ? 2'd1 : 2'd0;
        ctl_d.memory_to_register   = (cls == C_LW);
      end
      S_HALT:  ctl_d.halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      fn_q      <= '0;
      ctl_q     <= '0;
      fetch_q   <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctl_q     <= ctl_d;
      fetch_q   <= (state_d == S_FETCH);
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= func;
      end
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // The fetch strobes must answer mem_ready in the same cycle, so they are gated after the register.
  assign ir_write             = fetch_q & mem_ready;
  assign pc_write             = ctl_q.pc_write | (fetch_q & mem_ready);
  assign pc_write_cond        = ctl_q.pc_write_cond;
  assign pc_source            = ctl_q.pc_source;
  assign i_or_d               = ctl_q.i_or_d;
  assign mem_read             = ctl_q.mem_read;
  assign we_memory            = ctl_q.we_memory;
  assign memory_to_register   = ctl_q.memory_to_register;
  assign destination_register = ctl_q.destination_register;
  assign register_write       = ctl_q.register_write;
  assign ALU_src_a            = ctl_q.ALU_src_a;
  assign ALU_src_b            = ctl_q.ALU_src_b;
  assign ALU_OP               = ctl_q.ALU_OP;
  assign hilo_write           = ctl_q.hilo_write;
  assign busy                 = ctl_q.busy;
  assign halt                 = ctl_q.halt;
`ifdef ILLEGAL_TRAP_EN
  assign illegal              = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected output traces built from the instruction rules.
module tb_multicycle_controller;

  localparam int N_MD = 4;
  localparam int BASE = 13;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_J = 5, K_JAL = 6,
                 K_JR = 7, K_MD = 8, K_SYS = 9, K_UNK = 10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       we_memory;
    logic       memory_to_register;
    logic [1:0] destination_register;
    logic       register_write;
    logic       ALU_src_a;
    logic [1:0] ALU_src_b;
    logic [4:0] ALU_OP;
    logic       hilo_write;
    logic       busy;
    logic       halt;
    logic       ill;
  } out_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, func;
  logic       mem_ready;
  logic       ir_write, pc_write, pc_write_cond, i_or_d, mem_read, we_memory;
  logic       memory_to_register, register_write, ALU_src_a, hilo_write, busy, halt;
  logic [1:0] pc_source, destination_register, ALU_src_b;
  logic [4:0] ALU_OP;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  out_t       q_exp[$];
  logic       q_mr[$];
  logic [5:0] q_op[$];
  logic [5:0] q_fn[$];
  string      q_tag[$];

  always #5 clk = ~clk;

  multicycle_controller #(.ALU_OP_W(5), .MULDIV_CYCLES(N_MD), .BRANCH_OP_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .we_memory(we_memory),
    .memory_to_register(memory_to_register), .destination_register(destination_register),
    .register_write(register_write), .ALU_src_a(ALU_src_a), .ALU_src_b(ALU_src_b),
    .ALU_OP(ALU_OP), .hilo_write(hilo_write), .busy(busy), .halt(halt)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  function automatic out_t observe();
    out_t o;
    o.ir_write = ir_write;                   o.pc_write = pc_write;
    o.pc_write_cond = pc_write_cond;         o.pc_source = pc_source;
    o.i_or_d = i_or_d;                       o.mem_read = mem_read;
    o.we_memory = we_memory;                 o.memory_to_register = memory_to_register;
    o.destination_register = destination_register;
    o.register_write = register_write;       o.ALU_src_a = ALU_src_a;
    o.ALU_src_b = ALU_src_b;                 o.ALU_OP = ALU_OP;
    o.hilo_write = hilo_write;               o.busy = busy;
    o.halt = halt;
`ifdef ILLEGAL_TRAP_EN
    o.ill = illegal;
`else
    o.ill = 1'b0;
`endif
    return o;
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic int ref_kind(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                     6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12}) return K_R;
      if (fn == 6'h08) return K_JR;
      if (fn == 6'h0c) return K_SYS;
      if (fn inside {[6'h18:6'h1b]}) return K_MD;
      return K_UNK;
    end
    if (op inside {[6'h08:6'h0f]}) return K_I;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2b) return K_SW;
    if (op inside {6'h01, [6'h04:6'h07]}) return K_BR;
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    return K_UNK;
  endfunction

  // ALU op table: AND0 OR1 XOR2 NOR3 ADD4 ADDU5 SUB6 SUBU7 SLT8 SLTU9 SLL10 SRL11 SRA12 LUI18 MFHI19 MFLO20
  function automatic logic [4:0] ref_alu(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20: return 5'd4;   6'h21: return 5'd5;   6'h22: return 5'd6;   6'h23: return 5'd7;
        6'h24: return 5'd0;   6'h25: return 5'd1;   6'h26: return 5'd2;   6'h27: return 5'd3;
        6'h2a: return 5'd8;   6'h2b: return 5'd9;   6'h00: return 5'd10;  6'h02: return 5'd11;
        6'h03: return 5'd12;  6'h10: return 5'd19;  6'h12: return 5'd20;
        default: return 5'd4;
      endcase
    end
    case (op)
      6'h08: return 5'd4;   6'h09: return 5'd5;   6'h0a: return 5'd8;   6'h0b: return 5'd9;
      6'h0c: return 5'd0;   6'h0d: return 5'd1;   6'h0e: return 5'd2;   6'h0f: return 5'd18;
      6'h04: return 5'(BASE);     6'h05: return 5'(BASE + 1); 6'h06: return 5'(BASE + 2);
      6'h07: return 5'(BASE + 3); 6'h01: return 5'(BASE + 4);
      default: return 5'd4;
    endcase
  endfunction

  task automatic push(input logic mr, input logic [5:0] op, input logic [5:0] fn,
                      input out_t e, input string tag);
    q_mr.push_back(mr); q_op.push_back(op); q_fn.push_back(fn);
    q_exp.push_back(e); q_tag.push_back(tag);
  endtask

  task automatic push_halt(input int n, input logic ill, input logic [5:0] first_op);
    out_t e;
    e = '0; e.halt = 1'b1; e.ill = ill;
    for (int i = 0; i < n; i++)
      push(1'($urandom), (i == 0) ? first_op : rnd6(), rnd6(), e, "halt");
  endtask

  // Expected cycle-by-cycle trace of one instruction, from fetch to its last cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                       input string nm);
    out_t e;
    int   k;
    k = ref_kind(op, fn);
    e = '0; e.busy = 1; e.mem_read = 1; e.ALU_src_b = 2'd1; e.ALU_OP = 5'd4;
    for (int i = 0; i < fw; i++) push(1'b0, rnd6(), rnd6(), e, {nm, ".fetch_wait"});
    e.ir_write = 1; e.pc_write = 1;
    push(1'b1, rnd6(), rnd6(), e, {nm, ".fetch"});
    e = '0; e.busy = 1; e.ALU_src_b = 2'd3; e.ALU_OP = 5'd4;
    push(1'($urandom), op, fn, e, {nm, ".decode"});
    e = '0; e.busy = 1;
    case (k)
      K_R, K_BR: begin
        e.ALU_src_a = 1; e.ALU_OP = ref_alu(op, fn);
        if (k == K_BR) begin e.pc_write_cond = 1; e.pc_source = 2'd1; end
      end
      K_I, K_LW, K_SW: begin e.ALU_src_a = 1; e.ALU_src_b = 2'd2; e.ALU_OP = ref_alu(op, fn); end
      K_J:   begin e.pc_write = 1; e.pc_source = 2'd2; end
      K_JAL: begin e.pc_write = 1; e.pc_source = 2'd2; e.register_write = 1; e.destination_register = 2'd2; end
      K_JR:  begin e.pc_write = 1; e.pc_source = 2'd3; end
      default: ;
    endcase
    push(1'($urandom), rnd6(), rnd6(), e, {nm, ".execute"});
    if (k == K_LW || k == K_SW) begin
      e = '0; e.busy = 1; e.i_or_d = 1;
      if (k == K_LW) e.mem_read = 1; else e.we_memory = 1;
      for (int i = 0; i < mw; i++) push(1'b0, rnd6(), rnd6(), e, {nm, ".mem_wait"});
      push(1'b1, rnd6(), rnd6(), e, {nm, ".mem"});
    end
    if (k == K_R || k == K_I || k == K_LW) begin
      e = '0; e.busy = 1; e.register_write = 1;
      e.destination_register = (k == K_R) ? 2'd1 : 2'd0;
      e.memory_to_register = (k == K_LW);
      push(1'($urandom), rnd6(), rnd6(), e, {nm, ".writeback"});
    end
    if (k == K_MD) begin
      for (int i = 1; i <= N_MD; i++) begin
        e = '0; e.busy = 1; e.hilo_write = (i == N_MD);
        push(1'($urandom), rnd6(), rnd6(), e, {nm, ".muldiv"});
      end
    end
    if (k == K_SYS) push_halt(1, 1'b0, rnd6());
`ifdef ILLEGAL_TRAP_EN
    if (k == K_UNK) push_halt(1, 1'b1, rnd6());
`endif
  endtask

  task automatic step(output out_t got, output out_t exp, output string tag);
    @(posedge clk);
    #1;
    mem_ready = q_mr.pop_front();
    opcode    = q_op.pop_front();
    func      = q_fn.pop_front();
    exp       = q_exp.pop_front();
    tag       = q_tag.pop_front();
    @(negedge clk);
    got = observe();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    q_exp.delete(); q_mr.delete(); q_op.delete(); q_fn.delete(); q_tag.delete();
    @(negedge clk);
    release_reset();
  endtask

  task automatic test_reset();
    out_t got;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h23; func = 6'h20;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = observe();
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_state: observed %h expected %h", got, out_t'(0)); end
    release_reset();
    got = observe();
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL idle: observed %h expected %h", got, out_t'(0)); end
  endtask

  task automatic test_alu();
    out_t got, exp; string tag;
    build(6'h00, 6'h20, 0, 0, "ADD");
    build(6'h00, 6'h22, 1, 0, "SUB");
    build(6'h08, rnd6(), 0, 0, "ADDI");
    build(6'h0f, rnd6(), 0, 0, "LUI");
    build(6'h23, rnd6(), 2, 3, "LW");
    build(6'h2b, rnd6(), 0, 2, "SW");
    build(6'h2b, rnd6(), 0, 0, "SW0");
    while (q_exp.size() > 0) begin
      step(got, exp, tag);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", tag, got, exp); end
    end
  endtask

  task automatic test_control_flow();
    out_t got, exp; string tag;
    build(6'h04, rnd6(), 0, 0, "BEQ");
    build(6'h05, rnd6(), 0, 0, "BNE");
    build(6'h06, rnd6(), 0, 0, "BLEZ");
    build(6'h07, rnd6(), 0, 0, "BGTZ");
    build(6'h01, rnd6(), 0, 0, "BGEZ");
    build(6'h02, rnd6(), 0, 0, "J");
    build(6'h03, rnd6(), 1, 0, "JAL");
    build(6'h00, 6'h08, 0, 0, "JR");
    while (q_exp.size() > 0) begin
      step(got, exp, tag);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", tag, got, exp); end
    end
  endtask

  task automatic test_muldiv();
    out_t got, exp; string tag;
    build(6'h00, 6'h18, 0, 0, "MULT");
    build(6'h00, 6'h1b, 2, 0, "DIVU");
    while (q_exp.size() > 0) begin
      step(got, exp, tag);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", tag, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    out_t got, exp; string tag;
    logic [5:0] ops[22] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b,
                            6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [5:0] fns[22] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h18, 6'h1b, 6'h10};
    for (int i = 0; i < 30; i++) begin
      int j;
      logic [5:0] fn;
      j  = $urandom_range(0, 21);
      fn = (ops[j] == 6'h00) ? fns[j] : rnd6();
      build(ops[j], fn, $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end
    while (q_exp.size() > 0) begin
      step(got, exp, tag);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", tag, got, exp); end
    end
  endtask

  task automatic test_reset_muldiv();
    out_t got, exp; string tag;
    build(6'h00, 6'h1a, 0, 0, "DIV");
    for (int i = 0; i < 5; i++) begin
      step(got, exp, tag);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", tag, got, exp); end
    end
    #1;
    reset = 1'b1; mem_ready = 1'b1;
    q_exp.delete(); q_mr.delete(); q_op.delete(); q_fn.delete(); q_tag.delete();
    #1;
    got = observe();
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_async: observed %h expected %h", got, out_t'(0)); end
    @(negedge clk);
    got = observe();
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_hold: observed %h expected %h", got, out_t'(0)); end
    release_reset();
    got = observe();
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL idle_after_reset: observed %h expected %h", got, out_t'(0)); end
    build(6'h00, 6'h18, 0, 0, "MULT_after_reset");
    while (q_exp.size() > 0) begin
      step(got, exp, tag);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", tag, got, exp); end
    end
  endtask

  task automatic test_unknown_opcode();
    out_t got, exp; string tag;
    build(6'h3f, rnd6(), 0, 0, "UNK_OP");
`ifdef ILLEGAL_TRAP_EN
    push_halt(3, 1'b1, 6'h08);
`else
    build(6'h00, 6'h3f, 0, 0, "UNK_FN");
    build(6'h00, 6'h20, 0, 0, "ADD_after_unk");
`endif
    while (q_exp.size() > 0) begin
      step(got, exp, tag);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", tag, got, exp); end
    end
    pulse_reset();
  endtask

  task automatic test_syscall_halt();
    out_t got, exp; string tag;
    build(6'h00, 6'h0c, 0, 0, "SYSCALL");
    push_halt(6, 1'b0, 6'h08);
    while (q_exp.size() > 0) begin
      step(got, exp, tag);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: observed %h expected %h", tag, got, exp); end
    end
    pulse_reset();
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = '0; func = '0;
    test_reset();
    test_alu();
    test_control_flow();
    test_muldiv();
    test_back_to_back();
    test_reset_muldiv();
    test_unknown_opcode();
    test_syscall_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
